mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM pipeline stage plus MEM/WB register. Consumes the EXE_MEM_* bundle and performs the data-memory load/store over a ready-handshake port.
//   While a memory access is outstanding it stalls the upstream pipeline, and it resolves BEQ/BNE.
//   It registers the WB bundle and flags misaligned or timed-out accesses.
// PARAMETERS
//   ADDR_W     32  data-memory byte-address width (low ADDR_W bits of EXE_MEM_Result)
//   TIMEOUT    16  max wait cycles for dmem_ready before abort (>=1)
// PORTS
//   clk                    in   1   pipeline clock, rising edge
//   rst_n                  in   1   asynchronous, active-low reset
//   EXE_MEM_Result         in   32  ALU result / memory byte address
//   EXE_MEM_Rt             in   32  store data
//   EXE_MEM_BranchAddress  in   32  branch target
//   EXE_MEM_DstReg         in   5   destination register
//   EXE_MEM_Zero           in   1   ALU zero flag
//   EXE_MEM_BranchEqual    in   1   BEQ control
//   EXE_MEM_BranchnotEqual in   1   BNE control
//   EXE_MEM_MemRead        in   1   load control
//   EXE_MEM_MemWrite       in   1   store control
//   EXE_MEM_MemtoReg       in   1   WB mux select
//   EXE_MEM_RegWrite       in   1   WB enable
//   dmem_req               out  1   access request
//   dmem_we                out  1   1=write, 0=read
//   dmem_addr              out  ADDR_W  byte address, bits[1:0]=0
//   dmem_wdata             out  32  store data
//   dmem_rdata             in   32  load data, valid when dmem_ready=1
//   dmem_ready             in   1   access complete this cycle
//   MEM_PCSrc              out  1   take branch
//   MEM_BranchTarget       out  32  = EXE_MEM_BranchAddress
//   MEM_Stall              out  1   hold PC, IF/ID, ID/EXE and EXE/MEM registers
//   MEM_Fault              out  1   sticky misalign/timeout error
//   MEM_WB_ReadData        out  32  registered load data
//   MEM_WB_Result          out  32  registered ALU result
//   MEM_WB_DstReg          out  5   registered destination register
//   MEM_WB_MemtoReg        out  1   registered control
//   MEM_WB_RegWrite        out  1   registered control
// BEHAVIOUR
//   Reset: all registered outputs 0, FSM=IDLE, wait counter 0, MEM_Fault 0. Reset aborts any in-flight access; dmem_req drops immediately.
//   acc = MemRead|MemWrite. mis = acc & (Result[1:0]!=0). If both read and write are set, write wins.
//   FSM IDLE:
//     - acc & ~mis: dmem_req=1 combinationally.
//       dmem_ready=1 the same cycle: zero-wait completion, no stall.
//       Otherwise go to WAIT, MEM_Stall=1 this cycle, counter<=1.
//     - mis: no request, MEM_Fault<=1, MEM/WB loads a bubble.
//   FSM WAIT:
//     - dmem_req=1, MEM_Stall=1. Inputs are held stable because upstream is stalled.
//     - dmem_ready=1: completion, go to IDLE. MEM_Stall=0 in this cycle.
//     - Else if counter==TIMEOUT: abort, MEM_Fault<=1, MEM/WB loads a bubble, go to IDLE. MEM_Stall=0 in this cycle.
//     - Else counter++.
//   Bubble: MEM_WB_RegWrite=0, MEM_WB_MemtoReg=0, other MEM/WB fields 0.
//   MEM/WB register, every rising edge:
//     - If MEM_Stall=1 or on abort: load a bubble.
//     - Otherwise load the Result, DstReg, MemtoReg, RegWrite bundle. ReadData<=dmem_rdata on load completion, else 0.
//     - Latency: WB outputs are valid 1 cycle after the completion edge.
//   MEM_PCSrc = (BranchEqual&Zero)|(BranchnotEqual&~Zero), combinational and not gated by stall (branches never carry memory ops).
//   dmem_addr = {Result[ADDR_W-1:2],2'b00}. dmem_we = MemWrite. dmem_wdata = Rt.
//   dmem_ready is ignored when dmem_req=0.
//   MEM_Fault clears only on reset.
// TESTING
//   1 Load addr 0x40, dmem_ready held 1 -> no stall; next cycle MEM_WB_ReadData=rdata, RegWrite=1, MemtoReg=1.
//   2 Store addr 0x80 data 0xDEADBEEF, ready after 3 cycles -> MEM_Stall high exactly 3 cycles, dmem_we=1, one write seen, WB bubbles during stall.
//   3 Load, ready never asserted, TIMEOUT=16 -> stall drops after 16 wait cycles, MEM_Fault=1, MEM_WB_RegWrite=0.
//   4 Load addr 0x42 -> dmem_req never rises, MEM_Fault=1, WB bubble, no stall.
//   5 BNE, Zero=0 -> MEM_PCSrc=1, target=BranchAddress; BEQ, Zero=0 -> MEM_PCSrc=0.
//   6 rst_n low mid-WAIT -> dmem_req, MEM_Stall and all outputs 0 asynchronously; resumes in IDLE after release.

Source files
------------

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Data-memory request/ready port used by the MEM pipeline stage.
//   Ports (signals):
//     req    master->slave  access request
//     we     master->slave  1 = write, 0 = read
//     addr   master->slave  word-aligned byte address (ADDR_W bits)
//     wdata  master->slave  store data
//     rdata  slave->master  load data, valid when ready = 1
//     ready  slave->master  access completes this cycle
// -----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MEM pipeline stage plus MEM/WB register. Issues loads/stores on the dmem
//   port, stalls upstream while an access is outstanding, resolves BEQ/BNE and
//   flags misaligned or timed-out accesses in a sticky fault bit.
//   Ports:
//     clk, rst_n             clock / async active-low reset
//     EXE_MEM_*              EXE/MEM bundle (result/address, store data,
//                            branch target, dst reg, zero flag, controls)
//     dmem                   data-memory port (mem_stage_if.master)
//     MEM_PCSrc              take branch (combinational)
//     MEM_BranchTarget       branch target pass-through
//     MEM_Stall              hold PC, IF/ID, ID/EXE and EXE/MEM
//     MEM_Fault              sticky misalign/timeout error
//     MEM_WB_*               registered WB bundle
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       EXE_MEM_Result,
    input  logic [31:0]       EXE_MEM_Rt,
    input  logic [31:0]       EXE_MEM_BranchAddress,
    input  logic [4:0]        EXE_MEM_DstReg,
    input  logic              EXE_MEM_Zero,
    input  logic              EXE_MEM_BranchEqual,
    input  logic              EXE_MEM_BranchnotEqual,
    input  logic              EXE_MEM_MemRead,
    input  logic              EXE_MEM_MemWrite,
    input  logic              EXE_MEM_MemtoReg,
    input  logic              EXE_MEM_RegWrite,
    mem_stage_if.master       dmem,
    output logic              MEM_PCSrc,
    output logic [31:0]       MEM_BranchTarget,
    output logic              MEM_Stall,
    output logic              MEM_Fault,
    output logic [31:0]       MEM_WB_ReadData,
    output logic [31:0]       MEM_WB_Result,
    output logic [4:0]        MEM_WB_DstReg,
    output logic              MEM_WB_MemtoReg,
    output logic              MEM_WB_RegWrite
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_fault;

    logic w_acc, w_mis, w_ok, w_load;
    logic w_req, w_stall, w_complete, w_fault_set, w_bubble;

    assign w_acc  = EXE_MEM_MemRead | EXE_MEM_MemWrite;
    assign w_mis  = w_acc & (EXE_MEM_Result[1:0] != 2'b00);
    assign w_ok   = w_acc & ~w_mis;
    // Write wins when both controls are set, so this is a load only if MemWrite is clear.
    assign w_load = EXE_MEM_MemRead & ~EXE_MEM_MemWrite;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        w_fault_set = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_ok) begin
                    w_req = 1'b1;
                    if (dmem.ready) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end else if (w_mis) begin
                    w_fault_set = 1'b1;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (dmem.ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_fault_set = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stall, misalign and timeout abort all turn the MEM/WB load into a bubble.
    assign w_bubble = w_stall | w_fault_set;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_fault_set) r_fault <= 1'b1;
        end
    end

    // NOTE: only control/pipeline flops are reset; there is no storage array here needing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_WB_ReadData <= '0;
            MEM_WB_Result   <= '0;
            MEM_WB_DstReg   <= '0;
            MEM_WB_MemtoReg <= 1'b0;
            MEM_WB_RegWrite <= 1'b0;
        end else if (w_bubble) begin
            MEM_WB_ReadData <= '0;
            MEM_WB_Result   <= '0;
            MEM_WB_DstReg   <= '0;
            MEM_WB_MemtoReg <= 1'b0;
            MEM_WB_RegWrite <= 1'b0;
        end else begin
            MEM_WB_ReadData <= (w_complete && w_load) ? dmem.rdata : 32'h0;
            MEM_WB_Result   <= EXE_MEM_Result;
            MEM_WB_DstReg   <= EXE_MEM_DstReg;
            MEM_WB_MemtoReg <= EXE_MEM_MemtoReg;
            MEM_WB_RegWrite <= EXE_MEM_RegWrite;
        end
    end

    // Request and stall are forced low while reset is asserted so an in-flight
    // access is dropped immediately rather than at the next edge.
    assign dmem.req   = rst_n & w_req;
    assign dmem.we    = EXE_MEM_MemWrite;
    assign dmem.addr  = {EXE_MEM_Result[ADDR_W-1:2], 2'b00};
    assign dmem.wdata = EXE_MEM_Rt;
    assign MEM_Stall  = rst_n & w_stall;
    assign MEM_Fault  = r_fault;

    assign MEM_PCSrc        = (EXE_MEM_BranchEqual & EXE_MEM_Zero) |
                              (EXE_MEM_BranchnotEqual & ~EXE_MEM_Zero);
    assign MEM_BranchTarget = EXE_MEM_BranchAddress;
endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Scoreboard bench for mem_stage. The stimulus process issues one
//   instruction at a time; for every cycle it drives it pushes the expected
//   combinational outputs and the MEM/WB contents that must appear after the
//   edge. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_mem_stage;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] result, rt, baddr;
    logic [4:0]  dst;
    logic        zero, beq, bne, mread, mwrite, m2r, rw;
    logic        pcsrc, stall, fault, wb_m2r, wb_rw;
    logic [31:0] target, wb_rd, wb_res;
    logic [4:0]  wb_dst;

    mem_stage_if #(.ADDR_W(32)) dmem_bus ();

    mem_stage #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .EXE_MEM_Result         (result),
        .EXE_MEM_Rt             (rt),
        .EXE_MEM_BranchAddress  (baddr),
        .EXE_MEM_DstReg         (dst),
        .EXE_MEM_Zero           (zero),
        .EXE_MEM_BranchEqual    (beq),
        .EXE_MEM_BranchnotEqual (bne),
        .EXE_MEM_MemRead        (mread),
        .EXE_MEM_MemWrite       (mwrite),
        .EXE_MEM_MemtoReg       (m2r),
        .EXE_MEM_RegWrite       (rw),
        .dmem                   (dmem_bus.master),
        .MEM_PCSrc              (pcsrc),
        .MEM_BranchTarget       (target),
        .MEM_Stall              (stall),
        .MEM_Fault              (fault),
        .MEM_WB_ReadData        (wb_rd),
        .MEM_WB_Result          (wb_res),
        .MEM_WB_DstReg          (wb_dst),
        .MEM_WB_MemtoReg        (wb_m2r),
        .MEM_WB_RegWrite        (wb_rw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, we, stall, pcsrc, fault;
        logic [31:0] addr, wdata, target;
        logic [31:0] wb_rd, wb_res;
        logic [4:0]  wb_dst;
        logic        wb_m2r, wb_rw;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   model_fault = 1'b0;
    int   writes_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: combinational outputs of this cycle, plus the WB register
    // loaded at the edge that closed the previous cycle.
    initial begin
        exp_t e, prev;
        bit   have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (have_prev) begin
                    check("wb_readdata", wb_rd, prev.wb_rd);
                    check("wb_result",   wb_res, prev.wb_res);
                    check("wb_dstreg",   {27'd0, wb_dst}, {27'd0, prev.wb_dst});
                    check("wb_memtoreg", {31'd0, wb_m2r}, {31'd0, prev.wb_m2r});
                    check("wb_regwrite", {31'd0, wb_rw}, {31'd0, prev.wb_rw});
                end
                check("dmem_req", {31'd0, dmem_bus.req}, {31'd0, e.req});
                check("dmem_we",  {31'd0, dmem_bus.we}, {31'd0, e.we});
                check("dmem_addr", dmem_bus.addr, e.addr);
                check("dmem_wdata", dmem_bus.wdata, e.wdata);
                check("stall",    {31'd0, stall}, {31'd0, e.stall});
                check("pcsrc",    {31'd0, pcsrc}, {31'd0, e.pcsrc});
                check("target",   target, e.target);
                check("fault",    {31'd0, fault}, {31'd0, e.fault});
                if (dmem_bus.req && dmem_bus.we && dmem_bus.ready) writes_seen++;
                prev      = e;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    // One instruction. lat = cycle index (0 = first cycle) in which the memory
    // answers; lat > TIMEOUT means it never answers.
    task automatic issue(input logic [31:0] i_res, input logic [31:0] i_rt, input logic [31:0] i_ba,
                         input logic [4:0] i_dst, input logic i_zero, input logic i_beq, input logic i_bne,
                         input logic i_mr, input logic i_mw, input logic i_m2r, input logic i_rw,
                         input int lat, input logic [31:0] i_rdata);
        bit acc, mis, ok, tmo;
        int n;
        exp_t e;
        acc = i_mr | i_mw;
        mis = acc && (i_res % 4 != 0);
        ok  = acc && !mis;
        tmo = ok && (lat > TIMEOUT);
        if (!ok)      n = 1;
        else if (tmo) n = TIMEOUT + 1;
        else          n = lat + 1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            result = i_res; rt = i_rt; baddr = i_ba; dst = i_dst; zero = i_zero;
            beq = i_beq; bne = i_bne; mread = i_mr; mwrite = i_mw; m2r = i_m2r; rw = i_rw;
            dmem_bus.ready = ok ? (k == lat) : 1'($urandom);
            dmem_bus.rdata = (k == lat) ? i_rdata : $urandom;
            e.req    = ok;
            e.we     = i_mw;
            e.addr   = i_res - (i_res % 4);
            e.wdata  = i_rt;
            e.target = i_ba;
            e.pcsrc  = (i_beq && i_zero) || (i_bne && !i_zero);
            e.stall  = (k < n - 1);
            e.fault  = model_fault;
            if (e.stall || mis || tmo) begin
                e.wb_rd = 0; e.wb_res = 0; e.wb_dst = 0; e.wb_m2r = 0; e.wb_rw = 0;
            end else begin
                e.wb_rd  = (ok && i_mr && !i_mw) ? i_rdata : 32'h0;
                e.wb_res = i_res;
                e.wb_dst = i_dst;
                e.wb_m2r = i_m2r;
                e.wb_rw  = i_rw;
            end
            q.push_back(e);
            if (k == n - 1 && (mis || tmo)) model_fault = 1'b1;
        end
    endtask

    task automatic nop();
        issue($urandom, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic rand_instr(input bit allow_mis);
        logic [31:0] a;
        int kind, lat;
        kind = $urandom_range(0, 4);
        a    = $urandom;
        if (!(allow_mis && $urandom_range(0, 5) == 0)) a[1:0] = 2'b00;
        lat  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT) : $urandom_range(0, 3);
        case (kind)
            0: issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lat, $urandom);
            1: issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, lat, $urandom);
            2: issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, lat, $urandom);
            3: issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, lat, $urandom);
            default: issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, lat, $urandom);
        endcase
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        check("scoreboard_drained", q.size(), 0);
    endtask

    initial begin
        int writes_before;
        result = 0; rt = 0; baddr = 0; dst = 0; zero = 0; beq = 0; bne = 0;
        mread = 0; mwrite = 0; m2r = 0; rw = 0;
        dmem_bus.ready = 1'b0; dmem_bus.rdata = 32'h0;

        // Reset state, with a load presented so a leaking request would show.
        repeat (2) @(posedge clk);
        #1;
        mread = 1'b1; result = 32'h40;
        #1;
        check("rst_req",   {31'd0, dmem_bus.req}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_fault", {31'd0, fault}, 0);
        check("rst_wb_rw", {31'd0, wb_rw}, 0);
        check("rst_wb_res", wb_res, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait load at 0x40.
        issue(32'h40, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h1234_5678);
        nop();
        // Store 0xDEADBEEF at 0x80, ready after three stalled cycles.
        drain();
        writes_before = writes_seen;
        issue(32'h80, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0);
        nop();
        drain();
        check("store_write_count", writes_seen - writes_before, 1);
        // BNE with Zero=0 taken, BEQ with Zero=0 not taken.
        issue(32'h5, 32'h0, 32'h0000_1000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        issue(32'h5, 32'h0, 32'h0000_2000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

        for (int i = 0; i < 150; i++) rand_instr(1'b0);

        // Load that never completes, then a misaligned load.
        issue(32'h100, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, TIMEOUT + 1, 32'h0);
        nop();
        issue(32'h42, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0);
        nop();
        drain();

        // Reset asserted mid-WAIT: unscored cycles, checked directly.
        @(posedge clk); #1;
        result = 32'h200; mread = 1'b1; mwrite = 1'b0; m2r = 1'b1; rw = 1'b1;
        dmem_bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("wait_stall_before_rst", {31'd0, stall}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_req",   {31'd0, dmem_bus.req}, 0);
        check("midrst_stall", {31'd0, stall}, 0);
        check("midrst_fault", {31'd0, fault}, 0);
        check("midrst_wb_rw", {31'd0, wb_rw}, 0);
        check("midrst_wb_m2r", {31'd0, wb_m2r}, 0);
        check("midrst_wb_res", wb_res, 0);
        check("midrst_wb_rd",  wb_rd, 0);
        check("midrst_wb_dst", {27'd0, wb_dst}, 0);
        mread = 1'b0; m2r = 1'b0; rw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_fault = 1'b0;

        // Resumes in IDLE: zero-wait load completes with no stall.
        issue(32'h44, 32'h0, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'hCAFE_F00D);
        for (int i = 0; i < 150; i++) rand_instr(1'b1);
        nop();
        nop();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
